// File: rtl/qbert_only_mem_pkg.sv
// Shared types and helpers for the Qbert on-chip burst memory.
// Parity storage is enabled by defining QBERT_MEM_PARITY_EN at build time.
package qbert_only_mem_pkg;

    // Burst sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RBURST = 2'd1,
        ST_WBURST = 2'd2
    } mem_state_e;

    localparam int BYTE_W         = 8;
    localparam int DEFAULT_DATA_W = 32;
    localparam int BE_W           = DEFAULT_DATA_W / BYTE_W;

    // Ceiling log2, used to size address buses from a word count.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Number of byte lanes for a given data width.
    function automatic int be_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // Total parity bits stored per word: one per byte lane when enabled.
    function automatic int parity_width(input int data_w, input bit par_en);
        return par_en ? (data_w / BYTE_W) : 0;
    endfunction

endpackage

// File: rtl/qbert_only_ram_sp.sv
// Single-port RAM with per-lane write enables and a registered read port.
// Reads return the word stored before any write in the same cycle.
module qbert_only_ram_sp
    import qbert_only_mem_pkg::*;
#(
    parameter int    LANES     = 4,
    parameter int    LANE_W    = 8,
    parameter int    DEPTH     = 5000,
    parameter int    ADDR_W    = clog2(DEPTH),
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [LANES-1:0]         be,
    input  logic [LANES*LANE_W-1:0]  wdata,
    output logic [LANES*LANE_W-1:0]  rdata
);

    logic [LANES*LANE_W-1:0] mem [0:DEPTH-1];

    // Lane-masked write and registered read; everything holds while en is low.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < LANES; k++) begin
                if (we && be[k]) begin
                    mem[addr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/qbert_only_onchip_mem_burst.sv
// Avalon-MM on-chip RAM slave with linear bursts, waitrequest and readdatavalid.
// Define QBERT_MEM_PARITY_EN to store one even-parity bit per byte and flag readerror.
module qbert_only_onchip_mem_burst
    import qbert_only_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 5000,
    parameter int    ADDR_W       = 13,
    parameter int    BURST_W      = 4,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "qbert_only_onchip_mem.hex"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic                 reset_req,
    input  logic [ADDR_W-1:0]    address,
    input  logic [BURST_W-1:0]   burstcount,
    input  logic [DATA_W/8-1:0]  byteenable,
    input  logic                 chipselect,
    input  logic                 read,
    input  logic                 write,
    input  logic [DATA_W-1:0]    writedata,
    output logic                 waitrequest,
    output logic [DATA_W-1:0]    readdata,
    output logic                 readdatavalid,
    output logic                 readerror
);

`ifdef QBERT_MEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int LANES  = be_width(DATA_W);
    localparam int LANE_W = BYTE_W + parity_width(DATA_W, PAR_EN) / LANES;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic                     en;
    logic                     en_cmd;
    mem_state_e               state_q, state_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [BURST_W-1:0]       beat_q, beat_d;
    logic [BURST_W-1:0]       len_q, len_d;
    logic [BURST_W-1:0]       cmd_len;
    logic [ADDR_W-1:0]        beat_addr;
    logic                     last_beat;
    logic [ADDR_W-1:0]        ram_addr;
    logic                     addr_in_range;
    logic                     wr_beat;
    logic                     ram_we;
    logic                     issue;
    logic [LANES*LANE_W-1:0]  ram_wdata;
    logic [LANES*LANE_W-1:0]  ram_rdata;
    logic                     rv1_q, rv1_d;
    logic                     oor1_q, oor1_d;
    logic [DATA_W-1:0]        beat_data;
    logic [DATA_W-1:0]        stage1_data;
    logic                     stage1_err;
    logic                     out_valid;
    logic                     out_err;
    logic [DATA_W-1:0]        out_data;

    // A frozen cycle and a reset cycle both refuse new work.
    assign en        = clken & ~reset_req;
    assign en_cmd    = en & ~reset;
    assign cmd_len   = (burstcount == '0) ? BURST_W'(1) : burstcount;
    assign beat_addr = base_q + ADDR_W'(beat_q);
    assign last_beat = (beat_q == len_q - BURST_W'(1));

    // Burst state and beat bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
        end
    end

    // Next burst state: latch the base and length when a multi-beat command is taken.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        len_d   = len_q;
        if (en_cmd) begin
            case (state_q)
                ST_IDLE: begin
                    if (chipselect && (write || read) && (cmd_len > BURST_W'(1))) begin
                        base_d  = address;
                        beat_d  = BURST_W'(1);
                        len_d   = cmd_len;
                        state_d = write ? ST_WBURST : ST_RBURST;
                    end
                end
                ST_RBURST: begin
                    beat_d = beat_q + BURST_W'(1);
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_WBURST: begin
                    if (chipselect && write) begin
                        beat_d = beat_q + BURST_W'(1);
                        if (last_beat) begin
                            beat_d  = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Per-state handshake and RAM command; a write wins over a simultaneous read.
    always_comb begin
        waitrequest = 1'b1;
        ram_addr    = address;
        wr_beat     = 1'b0;
        issue       = 1'b0;
        if (en_cmd) begin
            case (state_q)
                ST_IDLE: begin
                    waitrequest = 1'b0;
                    if (chipselect && write) begin
                        wr_beat = 1'b1;
                    end else if (chipselect && read) begin
                        issue = 1'b1;
                    end
                end
                ST_RBURST: begin
                    ram_addr = beat_addr;
                    issue    = 1'b1;
                end
                ST_WBURST: begin
                    waitrequest = 1'b0;
                    ram_addr    = beat_addr;
                    wr_beat     = chipselect & write;
                end
                default: waitrequest = 1'b1;
            endcase
        end
    end

    assign addr_in_range = ({1'b0, ram_addr} < DEPTH_LIM);
    assign ram_we        = wr_beat & addr_in_range;

    // Pack write data into RAM lanes, adding an even-parity bit per byte when stored.
    always_comb begin
        ram_wdata = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef QBERT_MEM_PARITY_EN
            ram_wdata[k*LANE_W +: LANE_W] = {^writedata[k*BYTE_W +: BYTE_W],
                                             writedata[k*BYTE_W +: BYTE_W]};
`else
            ram_wdata[k*LANE_W +: LANE_W] = writedata[k*BYTE_W +: BYTE_W];
`endif
        end
    end

    qbert_only_ram_sp #(
        .LANES     (LANES),
        .LANE_W    (LANE_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (en),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (byteenable),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // First read stage tracks which RAM outputs are real beats and which were out of range.
    always_comb begin
        rv1_d  = rv1_q;
        oor1_d = oor1_q;
        if (en) begin
            rv1_d  = issue;
            oor1_d = ~addr_in_range;
        end
    end

    // First read stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rv1_q  <= 1'b0;
            oor1_q <= 1'b0;
        end else begin
            rv1_q  <= rv1_d;
            oor1_q <= oor1_d;
        end
    end

`ifdef QBERT_MEM_PARITY_EN
    logic [LANES-1:0] lane_bad;

    // Strip parity from the RAM word and flag any lane whose stored parity disagrees.
    always_comb begin
        beat_data = '0;
        lane_bad  = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_data[k*BYTE_W +: BYTE_W] = ram_rdata[k*LANE_W +: BYTE_W];
            lane_bad[k]                   = ^ram_rdata[k*LANE_W +: LANE_W];
        end
    end

    assign stage1_err = rv1_q & ~oor1_q & (|lane_bad);
`else
    // Without parity the RAM word is the data word.
    always_comb begin
        beat_data = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_data[k*BYTE_W +: BYTE_W] = ram_rdata[k*LANE_W +: BYTE_W];
        end
    end

    assign stage1_err = 1'b0;
`endif

    assign stage1_data = (rv1_q && !oor1_q) ? beat_data : '0;

    generate
        if (READ_LATENCY >= 2) begin : g_rl2
            logic              rv2_q, rv2_d;
            logic              err2_q, err2_d;
            logic [DATA_W-1:0] data2_q, data2_d;

            // Extra output stage, frozen together with the rest of the pipe.
            always_comb begin
                rv2_d   = rv2_q;
                err2_d  = err2_q;
                data2_d = data2_q;
                if (en) begin
                    rv2_d   = rv1_q;
                    err2_d  = stage1_err;
                    data2_d = stage1_data;
                end
            end

            // Extra output stage registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rv2_q   <= 1'b0;
                    err2_q  <= 1'b0;
                    data2_q <= '0;
                end else begin
                    rv2_q   <= rv2_d;
                    err2_q  <= err2_d;
                    data2_q <= data2_d;
                end
            end

            assign out_valid = rv2_q;
            assign out_err   = err2_q;
            assign out_data  = data2_q;
        end else begin : g_rl1
            assign out_valid = rv1_q;
            assign out_err   = stage1_err;
            assign out_data  = stage1_data;
        end
    endgenerate

    // Held beats are not re-presented while frozen, so the master never sees duplicates.
    assign readdatavalid = out_valid & en;
    assign readerror     = out_err & en;
    assign readdata      = out_data;

endmodule
